// File: rtl/audio_frame_sequencer.sv
// Host-side sequencer for the audio processor frame port: load, start, wait for done, unload, repeat.
// Optional WAIT-state watchdog compiled in with `define SEQ_TIMEOUT_EN.
module audio_frame_sequencer #(
    parameter int unsigned BEATS       = 64,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned FRAME_CNT_W = 16,
    parameter int unsigned TIMEOUT_CYC = 65536,
    localparam int unsigned IDX_W      = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   ap_data_wr_en,
    output logic [IDX_W-1:0]       ap_input_index,
    output logic [DATA_W-1:0]      ap_data_in,
    output logic                   ap_start,
    input  logic                   ap_done,
    output logic [IDX_W-1:0]       ap_output_index,
    input  logic [DATA_W-1:0]      ap_data_out,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frames_done,
    output logic                   run_done,
    output logic                   error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    logic [2:0]             r_state;
    logic [IDX_W-1:0]       r_beat;
    logic [FRAME_CNT_W-1:0] r_num_frames;
    logic [FRAME_CNT_W-1:0] r_frames_done;
    logic                   r_run_done;
    logic                   r_done_q;

    logic                   w_abort;
    logic                   w_beat_last;
    logic                   w_done_rise;
    logic                   w_load_fire;
    logic                   w_unload_fire;
    logic                   w_timeout;
    logic [FRAME_CNT_W-1:0] w_frames_inc;

    assign w_abort       = abort && (r_state != S_IDLE);
    assign w_beat_last   = (r_beat == IDX_W'(BEATS - 1));
    assign w_done_rise   = ap_done && !r_done_q;
    assign w_frames_inc  = r_frames_done + FRAME_CNT_W'(1);
    assign w_load_fire   = ap_data_wr_en;
    assign w_unload_fire = out_valid && out_ready;

    // Strobes drop in the abort cycle itself so nothing escapes after abort is seen.
    assign busy            = (r_state != S_IDLE);
    assign in_ready        = (r_state == S_LOAD) && !abort;
    assign ap_data_wr_en   = in_ready && in_valid;
    assign ap_input_index  = (r_state == S_LOAD) ? r_beat : '0;
    assign ap_data_in      = (r_state == S_LOAD) ? in_data : '0;
    assign ap_start        = (r_state == S_START) && !abort;
    assign out_valid       = (r_state == S_UNLOAD) && !abort;
    assign ap_output_index = (r_state == S_UNLOAD) ? r_beat : '0;
    assign out_data        = (r_state == S_UNLOAD) ? ap_data_out : '0;
    assign frames_done     = r_frames_done;
    assign run_done        = r_run_done;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_error;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    assign w_timeout = (r_state == S_WAIT) && !abort && !w_done_rise &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign error     = r_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if ((r_state == S_IDLE) && go) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    // Watchdog compiled out; the term only keeps the parameter referenced.
    assign w_timeout = 1'b0 && (TIMEOUT_CYC == 0);
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_num_frames  <= '0;
            r_frames_done <= '0;
            r_run_done    <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_done_q   <= ap_done;
            r_run_done <= 1'b0;
            if (w_abort) begin
                r_state    <= S_IDLE;
                r_run_done <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (go) begin
                            r_num_frames  <= num_frames;
                            r_frames_done <= '0;
                            r_beat        <= '0;
                            if (num_frames == '0) begin
                                r_run_done <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_load_fire) begin
                            r_beat <= r_beat + IDX_W'(1);
                            if (w_beat_last) begin
                                r_state <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_done_rise) begin
                            r_beat  <= '0;
                            r_state <= S_UNLOAD;
                        end else if (w_timeout) begin
                            r_run_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                    S_UNLOAD: begin
                        if (w_unload_fire) begin
                            r_beat <= r_beat + IDX_W'(1);
                            if (w_beat_last) begin
                                r_state <= S_NEXT;
                            end
                        end
                    end
                    S_NEXT: begin
                        r_frames_done <= w_frames_inc;
                        if (w_frames_inc == r_num_frames) begin
                            r_run_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_beat  <= '0;
                            r_state <= S_LOAD;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer: table of whole runs plus abort, zero-frame and
// (with SEQ_TIMEOUT_EN) watchdog sequences, with a small processor model.
module tb_audio_frame_sequencer;

    localparam int BEATS  = 64;
    localparam int DATA_W = 512;
    localparam int FCW    = 16;
    localparam int IDX_W  = 6;
    localparam int TMO    = 50;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic [FCW-1:0]    num_frames = '0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b1;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              ap_data_wr_en;
    logic [IDX_W-1:0]  ap_input_index;
    logic [DATA_W-1:0] ap_data_in;
    logic              ap_start;
    logic              ap_done = 1'b0;
    logic [IDX_W-1:0]  ap_output_index;
    logic [DATA_W-1:0] ap_data_out;
    logic              busy;
    logic [FCW-1:0]    frames_done;
    logic              run_done;
    logic              error;

    always #5 clk = ~clk;

    audio_frame_sequencer #(
        .BEATS      (BEATS),
        .DATA_W     (DATA_W),
        .FRAME_CNT_W(FCW),
        .TIMEOUT_CYC(TMO)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .go             (go),
        .num_frames     (num_frames),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .ap_data_wr_en  (ap_data_wr_en),
        .ap_input_index (ap_input_index),
        .ap_data_in     (ap_data_in),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_output_index(ap_output_index),
        .ap_data_out    (ap_data_out),
        .busy           (busy),
        .frames_done    (frames_done),
        .run_done       (run_done),
        .error          (error)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_total = 0, st_total = 0, rd_total = 0, rdone_total = 0, load_total = 0;
    int stall_cnt = 0, stall_left = 0;
    int rise_cyc = -100, start_cyc = 0, rdone_cyc = 0;
    int t_proc = 0, fall_at = 1, rise_at = 10;
    int abort_at = -1;
    bit prc_active = 0, toggle_mode = 0, stall_req = 0, stall_done = 0, prev_ov = 0;
    logic [IDX_W-1:0] wr_exp_idx = '0, rd_exp_idx = '0;

    // Processor output beat: index and frame tag replicated across the word.
    function automatic logic [DATA_W-1:0] mk_data(input logic [IDX_W-1:0] idx, input int tag);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) begin
            d[k*32 +: 32] = {8'hA5, tag[7:0], k[9:0], idx};
        end
        return d;
    endfunction

    assign ap_data_out = mk_data(ap_output_index, st_total);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkd(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act[63:0], exp[63:0]);
        end
    endtask

    // One clock: drive inputs #1 after the rising edge, sample and check on the falling edge.
    task automatic step_io(input bit g, input int nf, input bit a);
        bit trig;
        @(posedge clk);
        #1;
        cyc++;
        trig = (abort_at >= 0) && in_ready && (ap_input_index == IDX_W'(abort_at));
        if (trig) abort_at = -1;
        go         = g;
        num_frames = nf[FCW-1:0];
        abort      = a || trig;
        if (prc_active) begin
            t_proc++;
            if (t_proc == fall_at) ap_done = 1'b0;
            if (t_proc == rise_at) begin
                ap_done    = 1'b1;
                rise_cyc   = cyc;
                prc_active = 0;
            end
        end
        in_valid = toggle_mode ? (in_ready ? ~in_valid : 1'b1) : 1'b1;
        in_data  = {16{cyc}};
        if (stall_req && !stall_done && out_valid && ap_output_index == IDX_W'(17)) begin
            stall_left = 10;
            stall_done = 1;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end

        @(negedge clk);
        if (ap_data_wr_en || in_ready) chk("wr_en_vs_handshake", ap_data_wr_en, in_ready && in_valid);
        if (in_ready || out_valid) chk("ready_valid_exclusive", in_ready && out_valid, 0);
        if (in_ready) load_total++;
        if (ap_data_wr_en) begin
            chk("wr_index", ap_input_index, wr_exp_idx);
            chkd("wr_data", ap_data_in, in_data);
            wr_exp_idx++;
            wr_total++;
        end
        if (out_valid && !prev_ov) chk("unload_after_done_rise", cyc - rise_cyc, 1);
        prev_ov = out_valid;
        if (out_valid && !out_ready) begin
            stall_cnt++;
            chk("stall_index", ap_output_index, 17);
            chkd("stall_data", out_data, mk_data(IDX_W'(17), st_total));
        end
        if (out_valid && out_ready) begin
            chk("rd_index", ap_output_index, rd_exp_idx);
            chkd("rd_data", out_data, mk_data(rd_exp_idx, st_total));
            rd_exp_idx++;
            rd_total++;
        end
        if (run_done) begin
            rdone_total++;
            rdone_cyc = cyc;
        end
        if (ap_start) begin
            st_total++;
            start_cyc  = cyc;
            t_proc     = 0;
            prc_active = 1;
        end
    endtask

    task automatic step();
        step_io(0, 0, 0);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            step();
            if (run_done) seen = 1;
        end
        chk("run_done_within_budget", seen, 1);
    endtask

    typedef struct {
        int nf;
        bit toggle;
        int fall;
        int rise;
        bit stall;
        int exp_wr;
        int exp_st;
        int exp_rd;
        int exp_fd;
        int exp_load;
    } vec_t;

    vec_t vecs[4];
    int b_wr, b_st, b_rd, b_rdone, b_load;

    task automatic snap();
        b_wr    = wr_total;
        b_st    = st_total;
        b_rd    = rd_total;
        b_rdone = rdone_total;
        b_load  = load_total;
        wr_exp_idx = '0;
        rd_exp_idx = '0;
    endtask

    initial begin
        //          nf tog fall rise stall  wr   st  rd   fd  load
        vecs[0] = '{1, 0,  1,   100, 0,     64,  1,  64,  1,  64};
        vecs[1] = '{3, 1,  1,   30,  0,     192, 3,  192, 3,  384};
        vecs[2] = '{1, 0,  5,   20,  0,     64,  1,  64,  1,  64};  // ap_done high on WAIT entry
        vecs[3] = '{2, 0,  1,   10,  1,     128, 2,  128, 2,  128};

        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_frames_done", frames_done, 0);
        chk("rst_error", error, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_wr_en", ap_data_wr_en, 0);
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            toggle_mode = vecs[i].toggle;
            fall_at     = vecs[i].fall;
            rise_at     = vecs[i].rise;
            if (vecs[i].stall) stall_req = 1;
            snap();
            step_io(1, vecs[i].nf, 0);
            wait_done(6000);
            chk("run_busy_after_done", busy, 0);
            chk("run_frames_done", frames_done, vecs[i].exp_fd);
            step();
            step();
            chk("run_writes", wr_total - b_wr, vecs[i].exp_wr);
            chk("run_starts", st_total - b_st, vecs[i].exp_st);
            chk("run_reads", rd_total - b_rd, vecs[i].exp_rd);
            chk("run_load_cycles", load_total - b_load, vecs[i].exp_load);
            chk("run_done_pulses", rdone_total - b_rdone, 1);
            if (vecs[i].stall) chk("stall_cycles", stall_cnt, 10);
        end
        toggle_mode = 0;
        fall_at     = 1;
        rise_at     = 10;

        // Zero-frame run: immediate run_done, never busy, frames_done cleared.
        step_io(1, 0, 0);
        chk("zero_busy_go_cycle", busy, 0);
        step();
        chk("zero_run_done", run_done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_frames_done", frames_done, 0);
        step();
        chk("zero_run_done_pulse", run_done, 0);

        // Abort at LOAD beat 30.
        snap();
        abort_at = 30;
        step_io(1, 1, 0);
        begin
            bit hit = 0;
            for (int n = 0; n < 200 && !hit; n++) begin
                step();
                if (abort) hit = 1;
            end
            chk("abort_reached_beat30", hit, 1);
        end
        chk("abort_cycle_wr_en", ap_data_wr_en, 0);
        chk("abort_cycle_in_ready", in_ready, 0);
        step();
        chk("abort_busy_next", busy, 0);
        chk("abort_run_done_next", run_done, 1);
        repeat (5) step();
        chk("abort_writes", wr_total - b_wr, 30);
        chk("abort_starts", st_total - b_st, 0);
        chk("abort_run_done_pulses", rdone_total - b_rdone, 1);
        chk("abort_frames_done", frames_done, 0);

        // go and abort together in IDLE: go wins and the run completes.
        snap();
        step_io(1, 1, 1);
        wait_done(2000);
        chk("goabort_frames_done", frames_done, 1);
        step();
        chk("goabort_writes", wr_total - b_wr, 64);
        chk("goabort_reads", rd_total - b_rd, 64);
        chk("goabort_starts", st_total - b_st, 1);

`ifdef SEQ_TIMEOUT_EN
        rise_at = 0;
        snap();
        step_io(1, 1, 0);
        wait_done(500);
        chk("tmo_error", error, 1);
        chk("tmo_run_done_delay", rdone_cyc - start_cyc, TMO + 1);
        chk("tmo_reads", rd_total - b_rd, 0);
        chk("tmo_frames_done", frames_done, 0);
        chk("tmo_busy", busy, 0);
        rise_at = 10;
        step_io(1, 0, 0);
        step();
        chk("tmo_error_cleared", error, 0);
`else
        chk("error_tied_low", error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
